// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the SDF FFT sequencer
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Number of radix-2 stages for an n-point transform.
  function automatic int num_stages(input int n);
    return $clog2(n);
  endfunction

  // Count bit that drives stage s: stage 0 follows the MSB, the last stage the LSB.
  function automatic int ctrl_bit(input int s, input int num_s);
    return num_s - 1 - s;
  endfunction

endpackage

// File: rtl/fft_ctrl_dly.sv
// rtl/fft_ctrl_dly.sv - tapped delay line of {valid, count} for stage alignment
module fft_ctrl_dly #(
  parameter int W     = 4,
  parameter int DEPTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_valid,
  input  logic [W-1:0]       push_cnt,
  output logic [DEPTH-1:0]   tap_valid,
  output logic [DEPTH*W-1:0] tap_cnt
);

  logic [DEPTH-1:0] v_q;
  logic [W-1:0]     c_q [DEPTH];

  // Shift the accept marker and its count one tap per cycle; bubbles carry valid=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) c_q[k] <= '0;
    end else begin
      v_q    <= {v_q[DEPTH-2:0], push_valid};
      c_q[0] <= push_cnt;
      for (int k = 1; k < DEPTH; k++) c_q[k] <= c_q[k-1];
    end
  end

  assign tap_valid = v_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    assign tap_cnt[k*W +: W] = c_q[k];
  end

endmodule

// File: rtl/fft_sdf_ctrl.sv
// rtl/fft_sdf_ctrl.sv - sample/frame sequencer for a radix-2 SDF FFT pipeline
module fft_sdf_ctrl
  import fft_pkg::*;
#(
  parameter int N_POINTS  = 16,
  parameter int STAGE_LAT = 1,
  localparam int S        = num_stages(N_POINTS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush_req,
  output logic         zero_ins,
  output logic [S-1:0] stage_en,
  output logic [S-1:0] stage_ctrl,
  output logic         out_valid,
  output logic         out_sop,
  output logic [S-1:0] out_idx,
  output logic         flush_done,
  output logic         busy
);

  localparam int T     = S * STAGE_LAT;
  localparam int DEPTH = T + 1;
  localparam int DW    = $clog2(T + 1) + 1;

  state_t               state, state_nxt;
  logic [S-1:0]         cnt;
  logic                 primed;
  logic                 flush_pend;
  logic                 draining;
  logic [DW-1:0]        drain_cnt;
  logic [S-1:0]         ctrl_hold;
  logic [S-1:0]         cur_bit;
  logic [DEPTH-1:0]     tap_valid;
  logic [DEPTH*S-1:0]   tap_cnt;

  logic acc;
  logic cnt_zero;
  logic cnt_last;
  logic flush_last;
  logic primed_set;
  logic out_tap_v;

  assign cnt_zero   = (cnt == '0);
  assign cnt_last   = (cnt == S'(N_POINTS - 1));
  assign in_ready   = (state != FLUSH) & ~(flush_pend & cnt_zero & (state == RUN));
  assign zero_ins   = (state == FLUSH) & ~draining;
  assign acc        = (in_valid & in_ready) | zero_ins;
  assign flush_last = (state == FLUSH) & draining & (drain_cnt == DW'(T));
  assign flush_done = flush_last;
  assign busy       = (state != IDLE);

  fft_ctrl_dly #(
    .W     (S),
    .DEPTH (DEPTH)
  ) u_dly (
    .clk        (clk),
    .rst        (rst),
    .push_valid (acc),
    .push_cnt   (cnt),
    .tap_valid  (tap_valid),
    .tap_cnt    (tap_cnt)
  );

  assign out_tap_v  = tap_valid[T];
  assign out_idx    = tap_cnt[T*S +: S];
  assign primed_set = out_tap_v & (out_idx == S'(N_POINTS - 1));
  assign out_valid  = out_tap_v & primed;
  assign out_sop    = out_valid & (out_idx == '0);

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int TAP = s * STAGE_LAT;
    localparam int CB  = ctrl_bit(s, S);
    assign stage_en[s]   = tap_valid[TAP];
    assign cur_bit[s]    = tap_cnt[TAP*S + CB];
    assign stage_ctrl[s] = stage_en[s] ? cur_bit[s] : ctrl_hold[s];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: start on first accept, run once primed, flush at a frame boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = FILL;
      FILL:    if (primed | primed_set) state_nxt = RUN;
      RUN:     if (flush_pend & cnt_zero) state_nxt = FLUSH;
      FLUSH:   if (flush_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample counter advances on every accepted or injected sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cnt <= '0;
    else if (flush_last) cnt <= '0;
    else if (acc)        cnt <= cnt + 1'b1;
  end

  // Flush sequencing: one frame of zeros, then T+1 cycles to drain the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      draining  <= 1'b0;
      drain_cnt <= '0;
    end else if (flush_last) begin
      draining  <= 1'b0;
      drain_cnt <= '0;
    end else if (draining) begin
      drain_cnt <= drain_cnt + 1'b1;
    end else if (zero_ins & cnt_last) begin
      draining  <= 1'b1;
      drain_cnt <= '0;
    end
  end

  // primed marks that frame 1 has left the pipe; flush_pend latches a drain request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed     <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (flush_last)      primed <= 1'b0;
      else if (primed_set) primed <= 1'b1;

      if ((state == RUN) & (state_nxt == FLUSH))
        flush_pend <= 1'b0;
      else if (flush_req & ((state == FILL) | (state == RUN)))
        flush_pend <= 1'b1;
    end
  end

  // Remember each stage's last control bit so bubbles do not disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctrl_hold <= '0;
    else      ctrl_hold <= stage_ctrl;
  end

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// tb/tb_fft_sdf_ctrl.sv - scoreboard bench for fft_sdf_ctrl
module tb_fft_sdf_ctrl;

  localparam int N = 16;
  localparam int S = 4;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         flush_req;
  logic         in_ready;
  logic         zero_ins;
  logic [S-1:0] stage_en;
  logic [S-1:0] stage_ctrl;
  logic         out_valid;
  logic         out_sop;
  logic [S-1:0] out_idx;
  logic         flush_done;
  logic         busy;

  fft_sdf_ctrl #(.N_POINTS(N), .STAGE_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush_req  (flush_req),
    .zero_ins   (zero_ins),
    .stage_en   (stage_en),
    .stage_ctrl (stage_ctrl),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_idx    (out_idx),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int due;
    int idx;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: session-level view of accepts, frames and the flush sequence.
  int m_mode = 0;       // 0 idle, 1 streaming, 2 flushing
  int m_cnt = 0;
  int m_sess = 0;       // samples accepted since the session started
  int m_pend = 0;
  int m_zph = 0;        // flushing: still injecting zeros
  int m_drain = 0;      // flushing: drain cycles left
  int m_run_from = 0;   // first cycle frame 1 has fully left the pipe
  int rc = 0;           // first cycle after the latest reset
  bit hist_v [4096];
  int hist_i [4096];

  always @(negedge clk) begin
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_sess = 0; m_pend = 0; m_zph = 0; m_drain = 0;
      exp_q.delete();
      rc = cyc + 1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_outputs", {zero_ins, stage_en, stage_ctrl, out_valid, out_sop, out_idx, flush_done, busy}, 0);
    end else begin
      bit run, e_ready, e_zero, e_done, acc, go_flush;
      int old_cnt, old_mode;
      run     = (m_mode == 1) && (m_sess >= N) && (cyc >= m_run_from);
      e_ready = (m_mode != 2) && !(m_pend && m_cnt == 0 && run);
      e_zero  = (m_mode == 2) && m_zph;
      e_done  = (m_mode == 2) && !m_zph && (m_drain == 1);
      acc     = (in_valid && e_ready) || e_zero;
      chk("in_ready", in_ready, e_ready);
      chk("zero_ins", zero_ins, e_zero);
      chk("flush_done", flush_done, e_done);
      chk("busy", busy, m_mode != 0);

      for (int s = 0; s < S; s++) begin
        int k, ev, ec;
        k  = cyc - 1 - s;
        ev = (k >= rc) ? hist_v[k] : 0;
        ec = 0;
        for (int j = k; j >= rc; j--) begin
          if (hist_v[j]) begin
            ec = (hist_i[j] >> (S - 1 - s)) & 1;
            break;
          end
        end
        chk($sformatf("stage_en[%0d]", s), stage_en[s], ev);
        chk($sformatf("stage_ctrl[%0d]", s), stage_ctrl[s], ec);
      end

      hist_v[cyc] = acc;
      hist_i[cyc] = m_cnt;
      if (acc && m_sess >= N) exp_q.push_back('{due: cyc + T + 1, idx: m_cnt});

      old_cnt  = m_cnt;
      old_mode = m_mode;
      go_flush = run && m_pend && (m_cnt == 0);
      if (flush_req && m_mode == 1) m_pend = 1;
      if (acc) begin
        m_cnt = (m_cnt + 1) % N;
        m_sess++;
        if (m_sess == N) m_run_from = cyc + T + 2;
        if (old_mode == 0) m_mode = 1;
      end
      if (go_flush) begin
        m_mode = 2; m_zph = 1; m_pend = 0;
      end else if (old_mode == 2) begin
        if (m_zph) begin
          if (old_cnt == N - 1) begin
            m_zph = 0; m_drain = T + 1;
          end
        end else if (m_drain == 1) begin
          m_mode = 0; m_sess = 0; m_cnt = 0; m_drain = 0;
        end else begin
          m_drain--;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT presents a sample.
  always @(negedge clk) begin
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("out_valid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_due_cycle", cyc, e.due);
          chk("out_idx", out_idx, e.idx);
          chk("out_sop", out_sop, e.idx == 0);
        end
      end else if (out_sop) begin
        chk("out_sop_without_valid", 1, 0);
      end
    end
  end

  task automatic step(input bit iv, input bit fr);
    @(posedge clk);
    #1;
    in_valid  = iv;
    flush_req = fr;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    flush_req = 1'b0;
    repeat (5) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    flush_req = 1'b0;
    repeat (3) step(0, 0);

    // Frames 1 and 2 back to back.
    repeat (2 * N) step(1, 0);
    // Frame 3: flush request at sample 5, three-cycle gap, then the rest.
    for (int i = 0; i <= 5; i++) step(1, i == 5);
    repeat (3) step(0, 0);
    for (int i = 6; i < N; i++) step(1, 0);
    repeat (40) step(0, 0);

    // Reset mid frame 2 must clear everything at once.
    repeat (N + 10) step(1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_outputs", {zero_ins, stage_en, stage_ctrl, out_valid, out_sop, flush_done, busy}, 0);
    repeat (2) step(0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (N + 8) step(1, 0);
    repeat (10) step(0, 0);

    // Randomised traffic with occasional drain requests.
    repeat (300) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    repeat (40) step(0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_sdf_ctrl.md
Name: fft_sdf_ctrl

Overview:
Sequencer for an N-point radix-2 single-delay-feedback (SDF) FFT pipeline built from a chain of bfi butterfly stages. It owns the sample and frame count. For every stage it generates the stage enable and the fill/add control bit, time-aligned to that stage's data. It also tracks output validity and start-of-frame, and drives a zero-injection flush so the last frame can be drained.

Parameters:
N_POINTS, 16, FFT size; power of two, >= 4
STAGE_LAT, 1, clock cycles of data latency per butterfly stage
NUM_STAGES, $clog2(N_POINTS), derived (localparam S); stage s has feedback depth N_POINTS>>(s+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream sample present
in_ready  out  1  controller accepts a sample this cycle
flush_req  in  1  pulse; request drain after the current frame
zero_ins  out  1  upstream mux must present 0+j0 to stage 0 this cycle
stage_en  out  S  per-stage enable (bfi en)
stage_ctrl  out  S  per-stage control_bit (0 = fill, 1 = add/sub)
out_valid  out  1  last-stage output holds a valid frame sample
out_sop  out  1  out_valid and output index == 0
out_idx  out  S  sample index of the current output
flush_done  out  1  one-cycle pulse when the drain completes
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst=0): state=IDLE, cnt=0, delay line cleared, primed=0, flush_pend=0. All outputs are 0 except in_ready=1.
- Reset asserted mid-operation clears immediately with no partial-frame recovery. Stages share rst.
- Accept: acc = (in_valid & in_ready) | zero_ins.
  - On acc, cnt <= cnt+1 (S-bit, wraps N-1 -> 0).
  - On acc, push {1, cnt} into a delay line; otherwise push {0, hold}.
- Delay line: registered taps 0..S*STAGE_LAT. Tap k is valid k+1 cycles after the accept cycle.
- Stage s uses tap s*STAGE_LAT:
  - stage_en[s] = tap valid.
  - stage_ctrl[s] = tap count bit (S-1-s). Stage 0 fills for indices 0..N/2-1; the last stage toggles every sample.
  - When the tap is invalid, stage_ctrl holds its last value.
- Gaps (in_valid=0): cnt holds and the delay line carries bubbles. stage_en drops for exactly the bubble cycles at each tap, and the control sequence is unchanged.
- Output tap T = S*STAGE_LAT:
  - out_idx = tap T count.
  - out_valid = tap T valid & primed.
  - out_sop = out_valid & (out_idx == 0).
  - primed is set on the edge where tap T is valid with count N-1. It is cleared only by reset or flush completion, so frame 1 produces no out_valid.
- FSM states:
  - IDLE: moves to FILL on acc.
  - FILL: moves to RUN when primed becomes 1.
  - RUN: moves to FLUSH on a cycle with flush_pend & cnt==0.
  - FLUSH: zero_ins=1 for N cycles (cnt 0..N-1), then T+1 drain cycles. On completion: flush_done=1 for one cycle, primed<=0, cnt=0, state moves to IDLE.
- flush_pend:
  - Set by flush_req in FILL or RUN.
  - Cleared on entry to FLUSH.
  - flush_req in IDLE or FLUSH is ignored.
  - flush_req arriving mid-frame waits for the frame boundary (cnt==0).
  - A flush pending during FILL takes effect at the first RUN boundary.
- in_ready = (state != FLUSH) & ~(flush_pend & cnt==0 & state==RUN).
- Simultaneous events:
  - in_valid on the boundary cycle where FLUSH begins is not accepted (in_ready=0).
  - flush_req coinciding with cnt==0 in RUN takes effect at the next boundary (flush_pend is registered).

Decomposition:
- Package fft_pkg holds:
  - the state enum (IDLE, FILL, RUN, FLUSH)
  - the stage-count function num_stages(n)
  - the ctrl-bit index function ctrl_bit(s, S) = S-1-s
- One sub-module, fft_ctrl_dly: a parameterised shift register of {valid, count[S-1:0]} with async active-low clear that exposes all taps.
- Everything else stays in fft_sdf_ctrl.

Test Plan:
All scenarios use N_POINTS=16, STAGE_LAT=1, S=4, T=4.
1. Reset: drive rst=0 with random inputs -> in_ready=1, all other outputs 0, busy=0; release rst -> still idle.
2. Frame 1, 16 contiguous samples from cycle t0 -> stage_en[0] is high t0+1..t0+16; stage_ctrl[0] is 0 for 8 cycles then 1 for 8; stage_ctrl[3] alternates 0/1; stage_en[3] is high t0+4..t0+19; out_valid stays 0.
3. Frame 2 contiguous -> first out_valid=1 with out_sop=1 and out_idx=0 at t0+21; out_idx runs 0..15 over 16 cycles; state=RUN.
4. Three-cycle in_valid gap after sample 5 -> cnt holds at 6; each stage_en shows a 3-cycle hole delayed by s+1; stage_ctrl values after the gap match the no-gap sequence; out_idx is contiguous.
5. flush_req at sample 5 of frame 3 -> in_ready=0 at the frame-3 end boundary; zero_ins high 16 cycles; flush_done pulses 5 cycles after the last zero; frame-3 outputs all have out_valid=1; state ends IDLE, primed=0.
6. rst dropped at sample 10 of frame 2 -> all outputs clear the same cycle (async); next frame behaves as frame 1, with no out_valid.
